// File: rtl/currctrl_debug_capture_ctrl_if.sv
// Port-2 bus of the current-control debug RAM.
// The capture sequencer drives it as master; the RAM side is the slave.
interface currctrl_debug_capture_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              ram_chipselect;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_writedata;
    logic [3:0]        ram_byteenable;

    modport master (
        output ram_chipselect,
        output ram_write,
        output ram_address,
        output ram_writedata,
        output ram_byteenable
    );

    modport slave (
        input ram_chipselect,
        input ram_write,
        input ram_address,
        input ram_writedata,
        input ram_byteenable
    );
endinterface

// File: rtl/currctrl_debug_capture_ctrl.sv
// Capture sequencer: circular pre-trigger buffer into debug RAM port 2,
// freezing a programmed number of samples after the trigger.
module currctrl_debug_capture_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              trigger,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    currctrl_debug_capture_ctrl_if.master ram,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              wrapped
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   SIZE  = (ADDR_W + 1)'(DEPTH);

    state_t state;
    state_t state_n;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] post_q;
    logic [ADDR_W-1:0] post_clamp;
    logic [ADDR_W:0]   len_sum;

    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    logic take;
    logic start;
    logic hit;
    logic enter_done;

    assign cnt_inc = cnt + 1'b1;

    // Clamp so the trigger plus both windows never exceed the buffer.
    assign len_sum    = {1'b0, pre_len} + {1'b0, post_len};
    assign post_clamp = (len_sum >= SIZE) ? (MAX_A - pre_len) : post_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        take    = 1'b0;
        start   = 1'b0;
        hit     = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        start   = 1'b1;
                        state_n = (pre_len == '0) ? ARMED : PRE;
                    end
                end
                PRE: begin
                    take = sample_valid;
                    if (sample_valid && cnt_inc == pre_q) begin
                        state_n = ARMED;
                    end
                end
                ARMED: begin
                    take = sample_valid;
                    if (sample_valid && trigger) begin
                        hit     = 1'b1;
                        state_n = (post_q == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    take = sample_valid;
                    if (sample_valid && cnt_inc == post_q) begin
                        state_n = DONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign enter_done = (state_n == DONE) && (state != DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            wrapped    <= 1'b0;
            done       <= 1'b0;
            wr         <= 1'b0;
            addr       <= '0;
            data       <= '0;
        end else begin
            wr   <= take;
            done <= (state == DONE) && (state_n == DONE);
            if (take) begin
                addr   <= wr_ptr;
                data   <= sample_data;
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == MAX_A) begin
                    wrapped <= 1'b1;
                end
                if (state == PRE || state == POST) begin
                    cnt <= cnt_inc;
                end
            end
            if (hit) begin
                trig_addr <= wr_ptr;
                cnt       <= '0;
            end
            // Trigger address may still be in flight when post_q is zero.
            if (enter_done) begin
                start_addr <= (hit ? wr_ptr : trig_addr) - pre_q;
            end
            if (start) begin
                pre_q     <= pre_len;
                post_q    <= post_clamp;
                wr_ptr    <= '0;
                cnt       <= '0;
                wrapped   <= 1'b0;
                trig_addr <= '0;
            end
        end
    end

    assign busy = (state == PRE) || (state == ARMED) || (state == POST);

    assign ram.ram_chipselect = wr;
    assign ram.ram_write      = wr;
    assign ram.ram_address    = addr;
    assign ram.ram_writedata  = data;
    assign ram.ram_byteenable = 4'hF;

endmodule
